// File: rtl/ivs_mst.sv
// Single-outstanding AHB initiator: turns valid/ready commands into word-wide
// SINGLE read/write transfers, with a wait-state timeout that guarantees a response.
module ivs_mst #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic [1:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     wdata_q;
  logic            to_hit;

  assign cmd_ready = (state == IDLE);
  assign hsize     = 2'b10;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;

  // Abort on the last tolerated stall cycle of either phase.
  assign to_hit = (TIMEOUT != 0) && !hready && (to_cnt == TO_LAST);

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state       <= IDLE;
      htrans      <= 2'b00;
      hwrite      <= 1'b0;
      haddr       <= '0;
      hwdata      <= '0;
      wdata_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      to_cnt      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            hwrite  <= cmd_write;
            haddr   <= cmd_addr & 32'hFFFF_FFFC;
            wdata_q <= cmd_wdata;
            htrans  <= 2'b10;
            to_cnt  <= '0;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (hready) begin
            htrans <= 2'b00;
            if (hwrite) hwdata <= wdata_q;
            to_cnt <= '0;
            state  <= DATA;
          end else if (to_hit) begin
            htrans      <= 2'b00;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            to_cnt      <= '0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DATA: begin
          if (hready) begin
            if (!hwrite) rsp_rdata <= hrdata;
            rsp_valid   <= 1'b1;
            rsp_err     <= (hresp != 2'b00);
            rsp_timeout <= 1'b0;
            to_cnt      <= '0;
            state       <= IDLE;
          end else if (to_hit) begin
            htrans      <= 2'b00;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            to_cnt      <= '0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          htrans <= 2'b00;
          to_cnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ivs_mst.sv
// Directed bench for ivs_mst: each scenario task drives the command port and a
// hand-played AHB slave, then compares outputs against hand-computed values.
module tb_ivs_mst;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  int vectors = 0;
  int miscompares = 0;

  ivs_mst #(.TIMEOUT(4), .TO_W(8)) dut (
    .hclk(hclk), .hrst_n(hrst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hrst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    hready = 1'b1; hresp = 2'b00; hrdata = '0;
    #2;
    vectors++; if (htrans !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_htrans got %b exp 00", htrans); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
    vectors++; if ({rsp_err, rsp_timeout, hwrite} !== 3'b000) begin miscompares++; $display("[TB] FAIL rst_flags got %b exp 000", {rsp_err, rsp_timeout, hwrite}); end
    vectors++; if (haddr !== 32'h0 || hwdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_haddr_hwdata got %h/%h exp 0/0", haddr, hwdata); end
    vectors++; if ({hsize, hburst, hprot} !== {2'b10, 3'b000, 4'b0011}) begin miscompares++; $display("[TB] FAIL const_ctrl got %b exp 100000011", {hsize, hburst, hprot}); end
    step();
    hrst_n = 1'b1;
    step();
  endtask

  task automatic test_write_zero_wait();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h104; cmd_wdata = 32'hA5A5_0001;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ready_idle got %b exp 1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    vectors++; if (htrans !== 2'b10) begin miscompares++; $display("[TB] FAIL wr_htrans_addr got %b exp 10", htrans); end
    vectors++; if (haddr !== 32'h104 || hwrite !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_haddr got %h/%b exp 104/1", haddr, hwrite); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ready_addr got %b exp 0", cmd_ready); end
    step();
    vectors++; if (htrans !== 2'b00) begin miscompares++; $display("[TB] FAIL wr_htrans_data got %b exp 00", htrans); end
    vectors++; if (hwdata !== 32'hA5A5_0001) begin miscompares++; $display("[TB] FAIL wr_hwdata got %h exp a5a50001", hwdata); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_rsp_early got %b exp 0", rsp_valid); end
    step();
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_rsp got %b/%b exp 1/0", rsp_valid, rsp_err); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ready_rsp got %b exp 1", cmd_ready); end
    step();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_rsp_pulse got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read_one_wait();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200;
    step();
    cmd_valid = 1'b0;
    vectors++; if (htrans !== 2'b10 || hwrite !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_addr got %b/%b exp 10/0", htrans, hwrite); end
    step();
    hready = 1'b0; hrdata = 32'hFFFF_FFFF;
    step();
    vectors++; if (rsp_valid !== 1'b0 || htrans !== 2'b00) begin miscompares++; $display("[TB] FAIL rd_wait got %b/%b exp 0/00", rsp_valid, htrans); end
    hready = 1'b1; hrdata = 32'h1234_5678;
    step();
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_rsp got %b/%b exp 1/0", rsp_valid, rsp_err); end
    vectors++; if (rsp_rdata !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL rd_rdata got %h exp 12345678", rsp_rdata); end
    step();
  endtask

  task automatic test_error();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h300;
    step();
    cmd_valid = 1'b0;
    step();
    hready = 1'b0; hresp = 2'b01;
    step();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL err_first got %b exp 0", rsp_valid); end
    hready = 1'b1; hrdata = 32'hDEAD_BEEF;
    step();
    hresp = 2'b00;
    vectors++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin miscompares++; $display("[TB] FAIL err_rsp got %b exp 110", {rsp_valid, rsp_err, rsp_timeout}); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL err_idle got %b exp 1", cmd_ready); end
    vectors++; if (rsp_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL err_rdata got %h exp deadbeef", rsp_rdata); end
    step();
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h400;
    step();
    cmd_valid = 1'b0;
    step();
    hready = 1'b0; hrdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL to_stall%0d got %b/%b exp 0/0", i, rsp_valid, cmd_ready); end
      step();
    end
    vectors++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111) begin miscompares++; $display("[TB] FAIL to_rsp got %b exp 111", {rsp_valid, rsp_err, rsp_timeout}); end
    vectors++; if (rsp_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL to_rdata got %h exp deadbeef", rsp_rdata); end
    vectors++; if (htrans !== 2'b00 || cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL to_idle got %b/%b exp 00/1", htrans, cmd_ready); end
    hready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp_addr [3];
    logic        wr [3];
    addrs    = '{32'h500, 32'h107, 32'h508};
    exp_addr = '{32'h500, 32'h104, 32'h508};
    wr       = '{1'b1, 1'b0, 1'b1};
    hrdata = 32'hCAFE_0002;
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_write = wr[k]; cmd_addr = addrs[k]; cmd_wdata = 32'h7700_0000 + k;
      step();
      vectors++; if (cmd_ready !== 1'b0 || htrans !== 2'b10) begin miscompares++; $display("[TB] FAIL b2b%0d_addr got %b/%b exp 0/10", k, cmd_ready, htrans); end
      vectors++; if (haddr !== exp_addr[k]) begin miscompares++; $display("[TB] FAIL b2b%0d_haddr got %h exp %h", k, haddr, exp_addr[k]); end
      step();
      vectors++; if (cmd_ready !== 1'b0 || htrans !== 2'b00) begin miscompares++; $display("[TB] FAIL b2b%0d_data got %b/%b exp 0/00", k, cmd_ready, htrans); end
      if (wr[k]) begin
        vectors++; if (hwdata !== 32'h7700_0000 + k) begin miscompares++; $display("[TB] FAIL b2b%0d_hwdata got %h exp %h", k, hwdata, 32'h7700_0000 + k); end
      end
      step();
      vectors++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b%0d_rsp got %b/%b exp 1/1", k, rsp_valid, cmd_ready); end
      vectors++; if (rsp_rdata !== (k >= 1 ? 32'hCAFE_0002 : 32'hDEAD_BEEF)) begin miscompares++; $display("[TB] FAIL b2b%0d_rdata got %h", k, rsp_rdata); end
    end
    cmd_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h600; cmd_wdata = 32'h1;
    step();
    cmd_valid = 1'b0;
    vectors++; if (htrans !== 2'b10) begin miscompares++; $display("[TB] FAIL rm_addr got %b exp 10", htrans); end
    #2 hrst_n = 1'b0;
    #1;
    vectors++; if (htrans !== 2'b00 || cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_async got %b/%b exp 00/1", htrans, cmd_ready); end
    step();
    hrst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (rsp_valid !== 1'b0 || htrans !== 2'b00) begin miscompares++; $display("[TB] FAIL rm_after%0d got %b/%b exp 0/00", i, rsp_valid, htrans); end
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_one_wait();
    test_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ivs_mst.md
# ivs_mst

Single-transfer AHB initiator that turns a simple valid/ready command port into word-wide AHB single read/write transfers. It sits between firmware-style command sources (test sequencers, boot loaders, DMA control) and the AHB fabric, and drives the IVS register slave and peers. It carries one outstanding transfer at a time. A wait-state timeout guarantees that every command receives a response.

## Interface
Parameters:
- TIMEOUT, 255: maximum hready-low cycles tolerated in one phase; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- hclk  in  1  clock
- hrst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address; bits [1:0] ignored
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data; holds the last value
- rsp_err  out  1  hresp error or timeout, valid with rsp_valid
- rsp_timeout  out  1  timeout abort, valid with rsp_valid
- htrans  out  2  AHB transfer type
- hwrite  out  1  AHB direction
- haddr  out  32  AHB address
- hwdata  out  32  AHB write data
- hsize  out  2  constant 2'b10 (word)
- hburst  out  3  constant 3'b000 (SINGLE)
- hprot  out  4  constant 4'b0011
- hready  in  1  AHB ready from the fabric or slave
- hresp  in  2  AHB response; 2'b00 = OKAY
- hrdata  in  32  AHB read data

## Operation
- FSM has three states: IDLE, ADDR, DATA. Outputs are registered unless stated otherwise.
- IDLE
  - cmd_ready = 1 (combinational from state).
  - On cmd_valid, the block latches cmd_write, {cmd_addr[31:2],2'b00} and cmd_wdata, then moves to ADDR.
- ADDR
  - htrans = 2'b10 (NONSEQ); haddr and hwrite carry the latched command.
  - Moves to DATA at the first edge where hready = 1.
- DATA
  - htrans = 2'b00 (IDLE). hwdata = latched wdata for writes, otherwise it holds its last value.
  - At the first edge where hready = 1, the block captures hrdata (reads only) into rsp_rdata, sets rsp_err = (hresp != 2'b00), pulses rsp_valid and returns to IDLE.
- Error responses: the block does not cancel the transfer on the first ERROR cycle (hready = 0). It waits for the completing hready = 1 cycle and reports rsp_err = 1. On a read error, rsp_rdata is still updated with hrdata.
- Timeout
  - to_cnt counts cycles in ADDR or DATA with hready = 0 and clears on every state change.
  - When TIMEOUT != 0 and to_cnt == TIMEOUT - 1 with hready still 0, the block forces IDLE, drives htrans = 2'b00 and pulses rsp_valid with rsp_err = 1 and rsp_timeout = 1. rsp_rdata is unchanged.
- Commands arriving while the FSM is not in IDLE are held off by cmd_ready = 0 and are never dropped.

## Timing
- Reset (asynchronous, hrst_n = 0) takes effect immediately:
  - state = IDLE, htrans = 2'b00, hwrite = 0, haddr = 0, hwdata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_timeout = 0, to_cnt = 0.
  - cmd_ready = 1.
- Reset mid-transfer abandons the transfer with no response. htrans goes to IDLE immediately on reset assertion.
- Zero-wait-state path, with the command accepted at edge E:
  - Cycle E+1 is ADDR.
  - Cycle E+2 is DATA.
  - rsp_valid is high in cycle E+3.
- Each hready = 0 cycle in ADDR or DATA adds exactly one cycle of latency.
- rsp_valid lasts exactly one cycle and coincides with cmd_ready = 1. A new command accepted in that cycle is legal and starts ADDR in the next cycle.
- Throughput is at most one transfer per 3 cycles.
- haddr and hwrite are stable for the whole of ADDR. hwdata is stable for the whole of DATA.

## Test plan
- Write, zero wait: cmd_write = 1, addr 0x104, wdata 0xA5A5_0001.
  - Required: htrans = 10 for one cycle with haddr = 0x104; hwdata = 0xA5A5_0001 in the next cycle; rsp_valid 3 cycles after acceptance; rsp_err = 0.
- Read with one wait state: slave drives hready = 0 for one DATA cycle and returns hrdata 0x1234_5678.
  - Required: rsp_valid after 4 cycles, rsp_rdata = 0x1234_5678.
- Error response: hresp = 01 with hready = 0, then hresp = 01 with hready = 1.
  - Required: rsp_err = 1, rsp_timeout = 0, FSM back in IDLE.
- Timeout: TIMEOUT = 4, hready held at 0 in DATA.
  - Required: rsp_valid after exactly 4 stalled cycles with rsp_err = 1 and rsp_timeout = 1; rsp_rdata unchanged; htrans = 00.
- Back-to-back with alignment: cmd_valid held high for 3 commands, one with cmd_addr = 0x107.
  - Required: cmd_ready low during ADDR/DATA; 3 responses in order; the unaligned command drives haddr = 0x104.
- Reset mid-transfer: assert hrst_n = 0 during ADDR.
  - Required: htrans = 00 and cmd_ready = 1 immediately; no rsp_valid after release.
